// File: rtl/vpu_src_port_burst_ctrl.sv
// VPU source port: one fetch command -> sequential bank-interleaved SRAM reads into the operand FIFO.
// Define VPU_SRC_PORT_PERF_CNT_EN to add saturating stall/beat performance counters.
module vpu_src_port_burst_ctrl #(
  parameter int DATA_W         = 256,
  parameter int BANK_CNT_LG2   = 2,
  parameter int BANK_DEPTH_LG2 = 12,
  parameter int LEN_W          = 4,
  parameter int MAX_OUTST      = 4,
  parameter int SPACE_W        = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid_i,
  output logic                                 cmd_ready_o,
  input  logic [BANK_CNT_LG2+BANK_DEPTH_LG2-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]                     cmd_len_i,
  output logic                                 done_o,
  output logic                                 sram_req_o,
  input  logic                                 sram_ack_i,
  output logic [BANK_CNT_LG2-1:0]              sram_rid_o,
  output logic [BANK_DEPTH_LG2-1:0]            sram_addr_o,
  output logic                                 sram_reb_o,
  output logic                                 sram_rlast_o,
  input  logic [DATA_W-1:0]                    sram_rdata_i,
  input  logic                                 sram_rvalid_i,
  input  logic [SPACE_W-1:0]                   fifo_space_i,
  output logic [DATA_W-1:0]                    fifo_wdata_o,
  output logic                                 fifo_wren_o,
`ifdef VPU_SRC_PORT_PERF_CNT_EN
  output logic [31:0]                          perf_stall_cnt_o,
  output logic [31:0]                          perf_beat_cnt_o,
`endif
  output logic                                 err_o
);
  localparam int ADDR_W = BANK_CNT_LG2 + BANK_DEPTH_LG2;
  localparam int OUT_W  = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [ADDR_W-1:0]           r_base;
  logic [LEN_W-1:0]            r_len;
  logic [LEN_W-1:0]            r_beat;
  logic [OUT_W-1:0]            r_outst;
  logic                        r_req;
  logic [BANK_CNT_LG2-1:0]     r_rid;
  logic [BANK_DEPTH_LG2-1:0]   r_row;
  logic                        r_rlast;
  logic                        r_err;

  logic                        w_ack;
  logic                        w_wren;
  logic                        w_gate;
  logic                        w_last;
  logic [ADDR_W-1:0]           w_baddr;
  logic [OUT_W-1:0]            w_outst_nxt;

  assign w_ack       = r_req & sram_ack_i;
  assign w_wren      = sram_rvalid_i & (r_outst != '0);
  // each outstanding read already owns one FIFO slot
  assign w_gate      = (32'(r_outst) < 32'(MAX_OUTST)) &&
                       (32'(r_outst) < 32'(fifo_space_i));
  assign w_last      = (r_beat == r_len);
  assign w_baddr     = r_base + ADDR_W'(r_beat);
  assign w_outst_nxt = r_outst + OUT_W'(w_ack) - OUT_W'(w_wren);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (cmd_valid_i)        w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_ack && w_last)    w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_outst_nxt == '0)  w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (r_state == S_IDLE);
    done_o      = (r_state == S_IDLE);
    fifo_wren_o = w_wren;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_outst <= '0;
      r_req   <= 1'b0;
      r_rid   <= '0;
      r_row   <= '0;
      r_rlast <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && cmd_valid_i) begin
        r_base <= cmd_addr_i;
        r_len  <= cmd_len_i;
        r_beat <= '0;
      end
      // request drops for a cycle after each ack, then the gate is re-checked
      if (r_state == S_ISSUE) begin
        if (w_ack) begin
          r_req   <= 1'b0;
          r_rid   <= '0;
          r_row   <= '0;
          r_rlast <= 1'b0;
          r_beat  <= r_beat + 1'b1;
        end else if (!r_req && w_gate) begin
          r_req   <= 1'b1;
          r_rid   <= w_baddr[BANK_CNT_LG2-1:0];
          r_row   <= w_baddr[ADDR_W-1:BANK_CNT_LG2];
          r_rlast <= w_last;
        end
      end
      r_outst <= w_outst_nxt;
      if (sram_rvalid_i && r_outst == '0) r_err <= 1'b1;
    end
  end

  assign sram_req_o   = r_req;
  assign sram_reb_o   = ~r_req;
  assign sram_rid_o   = r_rid;
  assign sram_addr_o  = r_row;
  assign sram_rlast_o = r_rlast;
  assign fifo_wdata_o = sram_rdata_i;
  assign err_o        = r_err;

`ifdef VPU_SRC_PORT_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_beat_cnt;
  logic        w_stall;

  assign w_stall = (r_state == S_ISSUE) &&
                   (r_req ? !sram_ack_i : !w_gate);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_wren && r_beat_cnt != '1)   r_beat_cnt  <= r_beat_cnt + 1'b1;
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
  assign perf_beat_cnt_o  = r_beat_cnt;
`endif
endmodule

// File: tb/tb_vpu_src_port_burst_ctrl.sv
// Directed bench for vpu_src_port_burst_ctrl: cycle-driven SRAM/FIFO responder
// with hand-derived beat addresses and in-order data checks.
module tb_vpu_src_port_burst_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [13:0]  cmd_addr_i;
  logic [3:0]   cmd_len_i;
  logic         done_o;
  logic         sram_req_o;
  logic         sram_ack_i;
  logic [1:0]   sram_rid_o;
  logic [11:0]  sram_addr_o;
  logic         sram_reb_o;
  logic         sram_rlast_o;
  logic [255:0] sram_rdata_i;
  logic         sram_rvalid_i;
  logic [4:0]   fifo_space_i;
  logic [255:0] fifo_wdata_o;
  logic         fifo_wren_o;
  logic         err_o;
`ifdef VPU_SRC_PORT_PERF_CNT_EN
  logic [31:0]  perf_stall_cnt_o;
  logic [31:0]  perf_beat_cnt_o;
`endif

  vpu_src_port_burst_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_len_i     (cmd_len_i),
    .done_o        (done_o),
    .sram_req_o    (sram_req_o),
    .sram_ack_i    (sram_ack_i),
    .sram_rid_o    (sram_rid_o),
    .sram_addr_o   (sram_addr_o),
    .sram_reb_o    (sram_reb_o),
    .sram_rlast_o  (sram_rlast_o),
    .sram_rdata_i  (sram_rdata_i),
    .sram_rvalid_i (sram_rvalid_i),
    .fifo_space_i  (fifo_space_i),
    .fifo_wdata_o  (fifo_wdata_o),
    .fifo_wren_o   (fifo_wren_o),
`ifdef VPU_SRC_PORT_PERF_CNT_EN
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_beat_cnt_o  (perf_beat_cnt_o),
`endif
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int k);
    return {8{32'hD00D_0000 + 32'(k) * 32'h0001_0101}};
  endfunction

  task automatic run_burst(input logic [13:0] a, input logic [3:0] l,
                           input int space, input int ack_lat,
                           input int rv_lat, input int rv_hold,
                           input int exp_acks_hold, input int lim,
                           input int space0);
    int acks, wrs, m_out, max_out, age, bad_s0, n_beats;
    int due[$];
    logic held, ack, rv, fin;
    logic [1:0] hrid;
    logic [11:0] hrow;
    logic hlast;
    logic [13:0] ea;
    logic [255:0] ed;
    n_beats = int'(l) + 1;
    @(posedge clk); #1;
    cmd_valid_i  = 1'b1;
    cmd_addr_i   = a;
    cmd_len_i    = l;
    fifo_space_i = (space0 > 0) ? 5'd0 : 5'(space);
    #1 chk("cmd_ready", cmd_ready_o, 1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    chk("done_busy", done_o, 0);
    chk("req_first", sram_req_o, 0);
    acks = 0; wrs = 0; m_out = 0; max_out = 0; age = 0;
    bad_s0 = 0; held = 1'b0; fin = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      fifo_space_i = (c < space0) ? 5'd0 : 5'(space);
      if (held) begin
        chk("hold_req", sram_req_o, 1);
        chk("hold_fields", {sram_rid_o, sram_addr_o, sram_rlast_o},
            {hrid, hrow, hlast});
      end
      if (c < space0 && sram_req_o) bad_s0++;
      ack = sram_req_o && (age >= ack_lat);
      if (ack) age = 0;
      else if (sram_req_o) age++;
      rv = (due.size() > 0) && (due[0] <= c) && (c >= rv_hold);
      sram_ack_i    = ack;
      sram_rvalid_i = rv;
      sram_rdata_i  = pat(wrs);
      if (ack) begin
        ea = a + 14'(acks);
        chk("beat_rid", sram_rid_o, ea[1:0]);
        chk("beat_row", sram_addr_o, ea[13:2]);
        chk("beat_rlast", sram_rlast_o, (acks == int'(l)));
        chk("beat_reb", sram_reb_o, 0);
        acks++;
        due.push_back(c + rv_lat);
      end
      held  = sram_req_o && !ack;
      hrid  = sram_rid_o;
      hrow  = sram_addr_o;
      hlast = sram_rlast_o;
      #1;
      if (rv) begin
        ed = pat(wrs);
        chk("wren", fifo_wren_o, 1);
        chk("wdata_lo", fifo_wdata_o[63:0], ed[63:0]);
        chk("wdata_hi", fifo_wdata_o[255:192], ed[255:192]);
        wrs++;
        void'(due.pop_front());
      end else begin
        chk("no_wren", fifo_wren_o, 0);
      end
      m_out = m_out + (ack ? 1 : 0) - (rv ? 1 : 0);
      if (m_out > max_out) max_out = m_out;
      if (exp_acks_hold > 0 && c == rv_hold)
        chk("acks_at_hold", acks, exp_acks_hold);
      if (acks == n_beats && wrs == n_beats) begin
        fin = 1'b1;
        break;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    @(posedge clk); #1;
    sram_ack_i    = 1'b0;
    sram_rvalid_i = 1'b0;
    chk("done_after", done_o, 1);
    chk("req_after", sram_req_o, 0);
    chk("acks_total", acks, n_beats);
    chk("writes_total", wrs, n_beats);
    chk("max_outst_ok", (max_out <= lim), 1);
    if (space0 > 0) chk("no_req_space0", bad_s0, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    sram_ack_i = 1'b0; sram_rvalid_i = 1'b0; sram_rdata_i = '0;
    fifo_space_i = 5'd8;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req", sram_req_o, 0);
    chk("rst_reb", sram_reb_o, 1);
    chk("rst_rid", sram_rid_o, 0);
    chk("rst_addr", sram_addr_o, 0);
    chk("rst_rlast", sram_rlast_o, 0);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_done", done_o, 1);
    chk("rst_wren", fifo_wren_o, 0);
    chk("rst_err", err_o, 0);

    // single beat, ack one cycle late
    run_burst(14'h0005, 4'd0, 8, 1, 2, 0, 0, 1, 0);
    // address wrap across the top of the operand space
    run_burst(14'h3FFE, 4'd3, 8, 0, 1, 0, 0, 4, 0);
    // rvalid withheld: only MAX_OUTST acks before the first return
    run_burst(14'h0100, 4'd7, 8, 0, 1, 20, 4, 4, 0);
    // FIFO backpressure: zero space first, then one free entry
    run_burst(14'h0040, 4'd2, 1, 0, 2, 0, 0, 1, 4);
    // ack and rvalid coincide every issue cycle
    run_burst(14'h0200, 4'd15, 8, 0, 2, 0, 0, 1, 0);
    chk("err_clean", err_o, 0);

    // reset after two acks, then late data
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_addr_i = 14'h0010; cmd_len_i = 4'd7;
    fifo_space_i = 5'd8;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      sram_ack_i = sram_req_o;
      if (sram_req_o) n++;
    end
    chk("mid_acks", n, 2);
    @(posedge clk); #1;
    sram_ack_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_req", sram_req_o, 0);
    chk("mid_done", done_o, 1);
    for (int k = 0; k < 2; k++) begin
      sram_rvalid_i = 1'b1;
      sram_rdata_i  = pat(k);
      #1 chk("late_wren", fifo_wren_o, 0);
      @(posedge clk); #1;
    end
    sram_rvalid_i = 1'b0;
    chk("late_err", err_o, 1);
    chk("late_req", sram_req_o, 0);
    chk("late_done", done_o, 1);
    repeat (3) @(posedge clk);
    #1 chk("err_sticky", err_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_cleared", err_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
